// File: rtl/pipe_issue_ctrl.sv
// In-order issue scheduler for the 4-stage reg/ALU/mem pipeline: request FIFO,
// RAW hazard scoreboard (no forwarding downstream) and illegal-func filtering.
module pipe_issue_ctrl #(
  parameter int DEPTH    = 4,
  parameter int HAZ_WIN  = 2,
  parameter int MAX_FUNC = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_rs1,
  input  logic [3:0]               in_rs2,
  input  logic [3:0]               in_rd,
  input  logic [3:0]               in_func,
  input  logic [7:0]               in_addr,
  input  logic                     flush,
  output logic                     iss_valid,
  output logic [3:0]               iss_rs1,
  output logic [3:0]               iss_rs2,
  output logic [3:0]               iss_rd,
  output logic [3:0]               iss_func,
  output logic [7:0]               iss_addr,
  output logic                     stall,
  output logic                     illegal_func,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              issue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [3:0] func;
    logic [7:0] addr;
  } instr_t;

  typedef enum logic [2:0] {
    D_FLUSH,
    D_IDLE,
    D_DROP,
    D_STALL,
    D_ISSUE
  } decision_t;

  instr_t                    fifo_mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [CW-1:0]             count;
  logic [HAZ_WIN-1:0]        sb_v;
  logic [HAZ_WIN-1:0][3:0]   sb_rd;

  instr_t    head;
  logic      empty;
  logic      full;
  logic      hazard;
  logic      push;
  logic      pop;
  logic      do_issue;
  decision_t decision;

  assign head       = fifo_mem[rd_ptr];
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign in_ready   = !full;
  assign fifo_count = count;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (sb_v[i] && (sb_rd[i] == head.rs1 || sb_rd[i] == head.rs2)) hazard = 1'b1;
    end
  end

  always_comb begin
    decision = D_ISSUE;
    if (flush)                                 decision = D_FLUSH;
    else if (empty)                            decision = D_IDLE;
    else if (head.func > 4'(MAX_FUNC))         decision = D_DROP;
    else if (hazard)                           decision = D_STALL;
  end

  always_comb begin
    push         = in_valid && in_ready && !flush;
    pop          = (decision == D_DROP) || (decision == D_ISSUE);
    do_issue     = (decision == D_ISSUE);
    stall        = (decision == D_STALL);
    illegal_func = (decision == D_DROP);
  end

  // NOTE: storage is not reset; count alone decides which slots hold live entries.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Scoreboard keeps shifting through flush: already-issued work still writes back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v  <= '0;
      sb_rd <= '0;
    end else begin
      sb_v[0]  <= do_issue;
      sb_rd[0] <= head.rd;
      for (int i = 1; i < HAZ_WIN; i++) begin
        sb_v[i]  <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid   <= 1'b0;
      iss_rs1     <= '0;
      iss_rs2     <= '0;
      iss_rd      <= '0;
      iss_func    <= '0;
      iss_addr    <= '0;
      issue_count <= '0;
    end else begin
      iss_valid <= do_issue;
      if (do_issue) begin
        iss_rs1     <= head.rs1;
        iss_rs2     <= head.rs2;
        iss_rd      <= head.rd;
        iss_func    <= head.func;
        iss_addr    <= head.addr;
        issue_count <= issue_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Scoreboard bench for pipe_issue_ctrl: driver queues expected issues, a
// negedge monitor pops and compares them and gathers stall/illegal statistics.
module tb_pipe_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
  logic [7:0]  in_addr = '0;
  logic        flush = 1'b0;
  logic        iss_valid;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0]  iss_addr;
  logic        stall, illegal_func;
  logic [2:0]  fifo_count;
  logic [15:0] issue_count;

  pipe_issue_ctrl #(.DEPTH(4), .HAZ_WIN(2), .MAX_FUNC(11)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
    .flush(flush), .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_func(iss_func), .iss_addr(iss_addr), .stall(stall),
    .illegal_func(illegal_func), .fifo_count(fifo_count), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  logic [23:0] exp_q[$];
  int          iss_cyc[$];
  logic [15:0] exp_total = '0;
  int          stall_cnt = 0;
  int          illegal_cnt = 0;
  int          max_cnt = 0;
  bit          saw_backp = 0;
  logic [23:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every issue strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (iss_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 32'(iss_valid), 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("issue_fields", 32'({iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}), 32'(mon_exp));
        end
        iss_cyc.push_back(cyc);
      end
      if (stall)                 stall_cnt++;
      if (illegal_func)          illegal_cnt++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (in_valid && !in_ready) saw_backp = 1;
    end
  end

  function automatic int cyc_at(input int i);
    return (i < iss_cyc.size()) ? iss_cyc[i] : -100;
  endfunction

  task automatic clear_stats();
    stall_cnt   = 0;
    illegal_cnt = 0;
    max_cnt     = 0;
    saw_backp   = 0;
    iss_cyc.delete();
  endtask

  // Called at posedge+2; returns at posedge+2 of the cycle after acceptance.
  task automatic push(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                      input logic [3:0] func, input logic [7:0] addr, input bit expect_issue);
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_func = func; in_addr = addr;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) begin
      @(posedge clk); #2;
    end
    if (!in_ready) begin
      check("push_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (expect_issue) begin
      exp_q.push_back({rs1, rs2, rd, func, addr});
      exp_total++;
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #2;
      if (fifo_count == 0 && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    check("drain", 32'(done), 32'd1);
    repeat (4) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while rst_n is held low.
    #12;
    check("rst_iss_valid", 32'(iss_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_issue_count", 32'(issue_count), 32'd0);
    check("rst_stall_illegal", 32'({stall, illegal_func}), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: independent stream issues one per cycle.
    clear_stats();
    push(4'd3, 4'd5, 4'd10, 4'd0, 8'd125, 1);
    push(4'd3, 4'd8, 4'd12, 4'd2, 8'd126, 1);
    push(4'd7, 4'd3, 4'd13, 4'd1, 8'd127, 1);
    drain();
    check("t1_issues", 32'(iss_cyc.size()), 32'd3);
    check("t1_gap01", 32'(cyc_at(1) - cyc_at(0)), 32'd1);
    check("t1_gap12", 32'(cyc_at(2) - cyc_at(1)), 32'd1);
    check("t1_stalls", 32'(stall_cnt), 32'd0);
    check("t1_issue_count", 32'(issue_count), 32'(exp_total));

    // 2: RAW with one independent instruction in between.
    clear_stats();
    push(4'd3, 4'd5, 4'd10, 4'd0, 8'd128, 1);
    push(4'd3, 4'd8, 4'd12, 4'd2, 8'd129, 1);
    push(4'd10, 4'd5, 4'd14, 4'd1, 8'd130, 1);
    drain();
    check("t2_stalls", 32'(stall_cnt), 32'd1);
    check("t2_sub_after_add", 32'(cyc_at(2) - cyc_at(0)), 32'd3);

    // 3: back-to-back RAW.
    clear_stats();
    push(4'd3, 4'd5, 4'd10, 4'd0, 8'd131, 1);
    push(4'd10, 4'd5, 4'd14, 4'd1, 8'd132, 1);
    drain();
    check("t3_stalls", 32'(stall_cnt), 32'd2);
    check("t3_sub_after_add", 32'(cyc_at(1) - cyc_at(0)), 32'd3);

    // 4: illegal func dropped; its rd must not create a hazard.
    clear_stats();
    push(4'd1, 4'd2, 4'd4, 4'd0, 8'd10, 1);
    push(4'd1, 4'd2, 4'd9, 4'd13, 8'd11, 0);
    push(4'd9, 4'd6, 4'd7, 4'd11, 8'd12, 1);
    drain();
    check("t4_illegal_pulses", 32'(illegal_cnt), 32'd1);
    check("t4_issues", 32'(iss_cyc.size()), 32'd2);
    check("t4_gap", 32'(cyc_at(1) - cyc_at(0)), 32'd2);
    check("t4_stalls", 32'(stall_cnt), 32'd0);
    check("t4_issue_count", 32'(issue_count), 32'(exp_total));

    // 5: dependency chain fills the FIFO and applies backpressure.
    clear_stats();
    push(4'd0, 4'd0, 4'd1, 4'd0, 8'd20, 1);
    push(4'd1, 4'd1, 4'd2, 4'd0, 8'd21, 1);
    push(4'd2, 4'd2, 4'd3, 4'd0, 8'd22, 1);
    push(4'd3, 4'd3, 4'd4, 4'd0, 8'd23, 1);
    push(4'd4, 4'd4, 4'd5, 4'd0, 8'd24, 1);
    push(4'd5, 4'd5, 4'd6, 4'd0, 8'd25, 1);
    push(4'd6, 4'd6, 4'd7, 4'd0, 8'd26, 1);
    drain();
    check("t5_max_count", 32'(max_cnt), 32'd4);
    check("t5_backpressure", 32'(saw_backp), 32'd1);
    check("t5_stalls", 32'(stall_cnt), 32'd12);
    check("t5_issues", 32'(iss_cyc.size()), 32'd7);

    // 6a: flush discards three stalled entries and a same-cycle enqueue.
    clear_stats();
    push(4'd0, 4'd0, 4'd8, 4'd0, 8'd40, 1);
    push(4'd8, 4'd1, 4'd9, 4'd0, 8'd41, 0);
    push(4'd8, 4'd2, 4'd10, 4'd0, 8'd42, 0);
    push(4'd8, 4'd3, 4'd11, 4'd0, 8'd43, 0);
    check("t6_queued", 32'(fifo_count), 32'd3);
    flush = 1'b1;
    in_valid = 1'b1; in_rs1 = 4'd1; in_rs2 = 4'd1; in_rd = 4'd1; in_func = 4'd0; in_addr = 8'd44;
    @(posedge clk); #2;
    flush = 1'b0;
    in_valid = 1'b0;
    check("t6_flushed_count", 32'(fifo_count), 32'd0);
    drain();
    check("t6_issues", 32'(iss_cyc.size()), 32'd1);
    check("t6_issue_count", 32'(issue_count), 32'(exp_total));

    // 6b: asynchronous reset mid-stream.
    push(4'd1, 4'd2, 4'd3, 4'd1, 8'd50, 1);
    push(4'd4, 4'd5, 4'd6, 4'd2, 8'd51, 1);
    push(4'd7, 4'd8, 4'd9, 4'd3, 8'd52, 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_iss_valid", 32'(iss_valid), 32'd0);
    check("arst_iss_fields", 32'({iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}), 32'd0);
    check("arst_issue_count", 32'(issue_count), 32'd0);
    check("arst_fifo_count", 32'(fifo_count), 32'd0);
    check("arst_stall_illegal", 32'({stall, illegal_func}), 32'd0);
    exp_q.delete();
    exp_total = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    push(4'd2, 4'd3, 4'd4, 4'd5, 8'd60, 1);
    drain();
    check("post_rst_issue_count", 32'(issue_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
